// File: rtl/ps2_note_pkg.sv
// rtl/ps2_note_pkg.sv - note codes, scan-code constants and key map shared by the PS/2 note decoder
package ps2_note_pkg;

    localparam logic [3:0] NOTE_A    = 4'd0;
    localparam logic [3:0] NOTE_B    = 4'd1;
    localparam logic [3:0] NOTE_C    = 4'd2;
    localparam logic [3:0] NOTE_D    = 4'd3;
    localparam logic [3:0] NOTE_REST = 4'd15;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_B     = 8'h32;
    localparam logic [7:0] SC_C     = 8'h21;
    localparam logic [7:0] SC_D     = 8'h23;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        ST_MAKE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } sc_state_t;

    // Unmapped scan codes come back as NOTE_REST so callers can test for "no key".
    function automatic logic [3:0] map_scan(input logic [7:0] code);
        case (code)
            SC_A:    return NOTE_A;
            SC_B:    return NOTE_B;
            SC_C:    return NOTE_C;
            SC_D:    return NOTE_D;
            default: return NOTE_REST;
        endcase
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 receiver: synchroniser, clock glitch filter, 11-bit frame FSM with timeout
module ps2_rx
    import ps2_note_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_stb,
    output logic [7:0] byte_out,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          clk_s1, clk_s2, data_s1, data_s2;
    logic          filt_level;
    logic [FW-1:0] filt_cnt;
    logic          fall_en;

    rx_state_t     state, state_nxt;
    logic [TW-1:0] to_cnt;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
    logic          parity_ok;
    logic          stb_nxt, err_nxt, timeout;

    // The filtered level only flips after FILTER_LEN consecutive opposite samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1     <= 1'b1;
            clk_s2     <= 1'b1;
            data_s1    <= 1'b1;
            data_s2    <= 1'b1;
            filt_level <= 1'b1;
            filt_cnt   <= '0;
            fall_en    <= 1'b0;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
            fall_en <= 1'b0;
            if (clk_s2 == filt_level) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_level <= clk_s2;
                filt_cnt   <= '0;
                fall_en    <= ~clk_s2;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    assign timeout = (state != RX_IDLE) && !fall_en && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nxt = state;
        stb_nxt   = 1'b0;
        err_nxt   = 1'b0;
        if (timeout) begin
            state_nxt = RX_IDLE;
            err_nxt   = 1'b1;
        end else if (fall_en) begin
            case (state)
                RX_IDLE:   if (!data_s2) state_nxt = RX_DATA;
                RX_DATA:   if (bit_cnt == 3'd7) state_nxt = RX_PARITY;
                RX_PARITY: state_nxt = RX_STOP;
                RX_STOP: begin
                    state_nxt = RX_IDLE;
                    if (data_s2 && parity_ok) stb_nxt = 1'b1;
                    else                      err_nxt = 1'b1;
                end
                default:   state_nxt = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RX_IDLE;
            to_cnt    <= '0;
            shift     <= '0;
            bit_cnt   <= '0;
            parity_ok <= 1'b0;
            byte_stb  <= 1'b0;
            byte_out  <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            byte_stb  <= stb_nxt;
            frame_err <= err_nxt;
            if (stb_nxt) byte_out <= shift;
            if (state == RX_IDLE || fall_en) to_cnt <= '0;
            else                             to_cnt <= to_cnt + TW'(1);
            if (timeout) shift <= '0;
            if (fall_en) begin
                if (state == RX_IDLE) bit_cnt <= '0;
                if (state == RX_DATA) begin
                    shift   <= {data_s2, shift[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (state == RX_PARITY) parity_ok <= ^{shift, data_s2};
            end
        end
    end

endmodule

// File: rtl/ps2_note_decoder.sv
// rtl/ps2_note_decoder.sv - PS/2 make/break decoder driving a held note code (last key wins)
module ps2_note_decoder
    import ps2_note_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] note,
    output logic       byte_stb,
    output logic [7:0] byte_out,
    output logic       frame_err
);

    sc_state_t  sc_state, sc_nxt;
    logic [3:0] note_nxt;
    logic [3:0] key;

    ps2_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .byte_stb (byte_stb),
        .byte_out (byte_out),
        .frame_err(frame_err)
    );

    assign key = map_scan(byte_out);

    always_ff @(posedge clk) begin
        if (reset) begin
            sc_state <= ST_MAKE;
            note     <= NOTE_REST;
        end else begin
            sc_state <= sc_nxt;
            note     <= note_nxt;
        end
    end

    // Extended sequences are consumed but never change the note.
    always_comb begin
        sc_nxt   = sc_state;
        note_nxt = note;
        if (byte_stb) begin
            case (sc_state)
                ST_MAKE: begin
                    if (byte_out == SC_BREAK)    sc_nxt   = ST_BRK;
                    else if (byte_out == SC_EXT) sc_nxt   = ST_EXT;
                    else if (key != NOTE_REST)   note_nxt = key;
                end
                ST_BRK: begin
                    sc_nxt = ST_MAKE;
                    if (key != NOTE_REST && key == note) note_nxt = NOTE_REST;
                end
                ST_EXT:  sc_nxt = (byte_out == SC_BREAK) ? ST_EXT_BRK : ST_MAKE;
                default: sc_nxt = ST_MAKE;
            endcase
        end
    end

endmodule
